// File: rtl/stream_arbiter_mux_pkg.sv
// Shared types and sizing helpers for the stream arbiter mux and its grant logic.
// Holds no logic, so it adds no latency and has no backpressure behaviour of its own.
package stream_arbiter_mux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int MAX_CHANNELS = 16;

    // Wide enough to index any legal channel count; the round-robin search uses one extra bit for pointer+offset.
    localparam int CHANNEL_INDEX_WIDTH = $clog2(MAX_CHANNELS);

    function automatic int channel_index_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant: fixed-priority or round-robin search from pointer, overridden by a packet lock.
// Zero latency; a locked channel that drops valid gets no grant, so nobody else is granted either.
module rr_arbiter
    import stream_arbiter_mux_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int ROUND_ROBIN = 1,
    parameter int IW          = channel_index_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] valid,
    input  logic [IW-1:0]       pointer,
    input  logic                locked,
    input  logic [IW-1:0]       lock_ch,
    output logic [CHANNELS-1:0] grant,
    output logic [IW-1:0]       grant_idx
);

    localparam int CW = CHANNEL_INDEX_WIDTH + 1;

    logic [CW-1:0] cand;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        found     = 1'b0;
        if (locked) begin
            grant_idx      = lock_ch;
            grant[lock_ch] = valid[lock_ch];
        end else begin
            // Fixed priority is the round-robin search with the pointer pinned at 0.
            for (int k = 0; k < CHANNELS; k++) begin
                cand = (ROUND_ROBIN != 0) ? CW'(pointer) + CW'(k) : CW'(k);
                if (cand >= CW'(CHANNELS)) begin
                    cand = cand - CW'(CHANNELS);
                end
                if (!found && valid[IW'(cand)]) begin
                    found     = 1'b1;
                    grant_idx = IW'(cand);
                end
            end
            grant[grant_idx] = found;
        end
    end

endmodule

// File: rtl/stream_arbiter_mux.sv
// N:1 stream mux with round-robin/fixed arbitration and optional packet lock into a single output register.
// Latency 1 cycle; in_ready only asserts when the output register is empty or draining this cycle.
module stream_arbiter_mux
    import stream_arbiter_mux_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int CHANNELS    = 4,
    parameter int ROUND_ROBIN = 1,
    parameter int PACKET_LOCK = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [CHANNELS*WIDTH-1:0]   in_data,
    input  logic [CHANNELS-1:0]         in_valid,
    input  logic [CHANNELS-1:0]         in_last,
    output logic [CHANNELS-1:0]         in_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_valid,
    output logic                        out_last,
    output logic [$clog2(CHANNELS)-1:0] out_channel,
    input  logic                        out_ready
);

    localparam int IW = $clog2(CHANNELS);

    arb_state_t             state_q, state_d;
    logic [IW-1:0]          pointer_q, pointer_d;
    logic [IW-1:0]          lock_ch_q, lock_ch_d;
    logic [CHANNELS-1:0]    grant;
    logic [IW-1:0]          grant_idx;
    logic                   load_en;
    logic                   xfer;
    logic                   sel_last;
    logic [WIDTH-1:0]       sel_data;

    rr_arbiter #(
        .CHANNELS    (CHANNELS),
        .ROUND_ROBIN (ROUND_ROBIN),
        .IW          (IW)
    ) u_rr_arbiter (
        .valid     (in_valid),
        .pointer   (pointer_q),
        .locked    (state_q == LOCKED),
        .lock_ch   (lock_ch_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign load_en  = !out_valid || out_ready;
    assign in_ready = reset ? (grant & {CHANNELS{load_en}}) : '0;
    // Grant is already qualified by valid, so any ready bit is a transfer.
    assign xfer     = |in_ready;
    assign sel_last = in_last[grant_idx];
    assign sel_data = in_data[(CHANNELS - 1 - int'(grant_idx)) * WIDTH +: WIDTH];

    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        pointer_d = pointer_q;
        case (state_q)
            IDLE: begin
                if (xfer && (PACKET_LOCK != 0) && !sel_last) begin
                    state_d   = LOCKED;
                    lock_ch_d = grant_idx;
                end
            end
            LOCKED: begin
                if (xfer && sel_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (xfer && ((PACKET_LOCK == 0) || sel_last)) begin
            pointer_d = (grant_idx == IW'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            pointer_q   <= '0;
            lock_ch_q   <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            out_channel <= '0;
        end else begin
            state_q   <= state_d;
            pointer_q <= pointer_d;
            lock_ch_q <= lock_ch_d;
            if (load_en) begin
                out_valid <= xfer;
                if (xfer) begin
                    out_data    <= sel_data;
                    out_last    <= sel_last;
                    out_channel <= grant_idx;
                end
            end
        end
    end

endmodule
